// File: rtl/fft_reorder_if.sv
// Sample stream bundle between the last R2SDF butterfly stage and the reorder block.
// Ports: start_ip/ip_re/ip_im carry the bit-reversed input stream;
//        op_re/op_im/valid_op/start_op carry the natural-order output stream.
interface fft_reorder_if #(
  parameter int W = 32
);
  logic                start_ip;
  logic signed [W-1:0] ip_re;
  logic signed [W-1:0] ip_im;
  logic signed [W-1:0] op_re;
  logic signed [W-1:0] op_im;
  logic                valid_op;
  logic                start_op;

  // master: the side producing the butterfly stream and consuming the reordered stream
  modport master (
    output start_ip, ip_re, ip_im,
    input  op_re, op_im, valid_op, start_op
  );

  // slave: the reorder block itself
  modport slave (
    input  start_ip, ip_re, ip_im,
    output op_re, op_im, valid_op, start_op
  );
endinterface

// File: rtl/fft_reorder.sv
// Bit-reversed to natural order converter for a 2^N-point R2SDF FFT, using two
// ping-pong banks of 2^N complex words. Output index j of a frame whose start_ip
// was at t0 appears at t0+2^N+1+j; no backpressure (streaming, one sample/clk).
// Ports: clk, reset (async, active-high), io (fft_reorder_if.slave: input stream
// start_ip/ip_re/ip_im, registered output stream op_re/op_im/valid_op/start_op).
// Optional build macro FFT_REORDER_SCALE_EN: outputs are arithmetically shifted
// right by N (1/2^N normalization); latency is the same in both builds.
module fft_reorder #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          reset,
  fft_reorder_if.slave  io
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] LAST = N'(DEPTH - 1);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int b = 0; b < N; b++) r[b] = a[N-1-b];
    return r;
  endfunction

  // Bank storage: deliberately not reset.
  logic signed [W-1:0] mem_re [0:1][0:DEPTH-1];
  logic signed [W-1:0] mem_im [0:1][0:DEPTH-1];

  // ---------------- write side ----------------
  logic         wr_act;
  logic [N-1:0] wr_cnt;
  logic         wr_bank;
  logic         wr_en;
  logic [N-1:0] wr_addr;
  logic         wr_done;

  // start_ip always wins: it restarts the current bank at address 0, which
  // also discards a partially written frame.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_done = 1'b0;
    if (io.start_ip) begin
      wr_en   = 1'b1;
      wr_addr = '0;
    end else if (wr_act) begin
      wr_en   = 1'b1;
      wr_addr = wr_cnt;
      wr_done = (wr_cnt == LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act  <= 1'b0;
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (io.start_ip) begin
      wr_act <= 1'b1;
      wr_cnt <= N'(1);
    end else if (wr_act) begin
      if (wr_done) begin
        wr_act  <= 1'b0;
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_bank][wr_addr] <= io.ip_re;
      mem_im[wr_bank][wr_addr] <= io.ip_im;
    end
  end

  // ---------------- read side ----------------
  state_t       state_q, state_d;
  logic [N-1:0] rd_idx_q, rd_idx_d;
  logic         rd_bank_q, rd_bank_d;
  logic [1:0]   full_q, full_d;
  logic         rd_en;
  logic         rd_first;
  logic         rd_release;
  logic [N-1:0] rd_idx_cur;
  logic         other_bank;

  assign other_bank = ~rd_bank_q;

  // IDLE fetches index 0 in the same cycle it sees a full bank, so the first
  // output lands one cycle after the bank fills. Banks fill and drain in the
  // same 0,1,0,1 order, so rd_bank_q always names the next bank to drain.
  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    rd_bank_d  = rd_bank_q;
    rd_en      = 1'b0;
    rd_first   = 1'b0;
    rd_release = 1'b0;
    rd_idx_cur = '0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_en    = 1'b1;
          rd_first = 1'b1;
          state_d  = READ;
          rd_idx_d = N'(1);
        end
      end
      READ: begin
        rd_en      = 1'b1;
        rd_idx_cur = rd_idx_q;
        rd_first   = (rd_idx_q == '0);
        if (rd_idx_q == LAST) begin
          rd_release = 1'b1;
          rd_bank_d  = other_bank;
          rd_idx_d   = '0;
          state_d    = full_q[other_bank] ? READ : IDLE;
        end else begin
          rd_idx_d = rd_idx_q + N'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Release and fill of the two banks are independent and may coincide.
  always_comb begin
    full_d = full_q;
    if (rd_release) full_d[rd_bank_q] = 1'b0;
    if (wr_done)    full_d[wr_bank]   = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  // ---------------- output register ----------------
  logic [N-1:0]        rd_addr;
  logic signed [W-1:0] rd_re, rd_im;
  logic signed [W-1:0] op_re_q, op_im_q;
  logic                valid_q, start_q;

  assign rd_addr = bitrev(rd_idx_cur);
  assign rd_re   = mem_re[rd_bank_q][rd_addr];
  assign rd_im   = mem_im[rd_bank_q][rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_re_q <= '0;
      op_im_q <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else if (rd_en) begin
`ifdef FFT_REORDER_SCALE_EN
      op_re_q <= rd_re >>> N;
      op_im_q <= rd_im >>> N;
`else
      op_re_q <= rd_re;
      op_im_q <= rd_im;
`endif
      valid_q <= 1'b1;
      start_q <= rd_first;
    end else begin
      op_re_q <= '0;
      op_im_q <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end
  end

  assign io.op_re    = op_re_q;
  assign io.op_im    = op_im_q;
  assign io.valid_op = valid_q;
  assign io.start_op = start_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder (N=3, W=32): single frame, back-to-back frames,
// restart mid-frame, reset during read and during write, idle input ignored.
// Ports: none; instantiates fft_reorder_if and fft_reorder.
module tb_fft_reorder;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   perm [8];

`ifdef FFT_REORDER_SCALE_EN
  localparam int SH = 3;
`else
  localparam int SH = 0;
`endif

  fft_reorder_if #(.W(32)) bus ();

  fft_reorder #(.N(3), .W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] sc(input logic signed [31:0] x);
    return x >>> SH;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic es,
                         input logic signed [31:0] er, input logic signed [31:0] ei);
    chk({tag, ".valid_op"}, {31'd0, bus.valid_op}, {31'd0, ev});
    chk({tag, ".start_op"}, {31'd0, bus.start_op}, {31'd0, es});
    chk({tag, ".op_re"}, bus.op_re, er);
    chk({tag, ".op_im"}, bus.op_im, ei);
  endtask

  // Drive one cycle of input, check outputs for that same cycle, advance.
  task automatic step(input string tag, input logic st,
                      input logic signed [31:0] re, input logic signed [31:0] im,
                      input logic ev, input logic es,
                      input logic signed [31:0] er, input logic signed [31:0] ei);
    bus.start_ip = st;
    bus.ip_re    = re;
    bus.ip_im    = im;
    chk_out(tag, ev, es, er, ei);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic                ev, es;
    logic signed [31:0]  er, ei, re, im;
    int                  j, k, f;

    perm = '{0, 4, 2, 6, 1, 5, 3, 7};

    reset        = 1'b1;
    bus.start_ip = 1'b0;
    bus.ip_re    = '0;
    bus.ip_im    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 0, 0);
    reset = 1'b0;

    // Data without start_ip is ignored.
    for (int i = 0; i < 6; i++)
      step("idle", 1'b0, (i + 1) * 65536, -i, 1'b0, 1'b0, 0, 0);

    // Single frame: ip_re = k*65536, outputs from t0+9 in bit-reversed order.
    for (int i = 0; i < 18; i++) begin
      j = i - 9;
      ev = (j >= 0 && j < 8);
      es = (j == 0);
      er = 0;
      if (ev) er = sc(perm[j] * 65536);
      step("single", i == 0, i * 65536, 0, ev, es, er, 0);
    end

    // Back-to-back frames; second frame sample 0 is negative, im = 100+k.
    for (int i = 0; i < 28; i++) begin
      k = i % 8;
      if (i < 8) begin
        re = k * 65536; im = 0;
      end else if (i < 16) begin
        re = (k == 0) ? -65536 : k * 65536; im = 100 + k;
      end else begin
        re = i * 65536; im = 7;
      end
      j  = i - 9;
      ev = (j >= 0 && j < 16);
      es = ev && (j % 8 == 0);
      er = 0; ei = 0;
      if (ev) begin
        f = j / 8;
        k = perm[j % 8];
        if (f == 0) begin
          er = sc(k * 65536); ei = 0;
        end else begin
          er = sc((k == 0) ? -65536 : k * 65536); ei = sc(100 + k);
        end
      end
      step("b2b", (i == 0) || (i == 8), re, im, ev, es, er, ei);
    end

    // Restart at t0+3 discards the partial frame; output from t0+12.
    for (int i = 0; i < 24; i++) begin
      j  = i - 12;
      ev = (j >= 0 && j < 8);
      es = (j == 0);
      er = 0; ei = 0;
      if (ev) begin
        k  = perm[j];
        er = sc((3 + k) * 65536);
        ei = sc(-(3 + k));
      end
      step("restart", (i == 0) || (i == 3), i * 65536, -i, ev, es, er, ei);
    end

    // Reset during read: outputs j=0,1 seen, then reset at t0+11.
    for (int i = 0; i < 11; i++) begin
      j  = i - 9;
      ev = (j >= 0);
      es = (j == 0);
      er = 0;
      if (ev) er = sc((perm[j] + 1) * 65536);
      step("rd_rst", i == 0, (i + 1) * 65536, 0, ev, es, er, 0);
    end
    bus.start_ip = 1'b0;
    reset = 1'b1;
    #1;
    chk_out("rd_rst.async", 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("rd_rst.held", 1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++)
      step("rd_rst.after", 1'b0, 65536, 5, 1'b0, 1'b0, 0, 0);

    // Reset during write: the partial frame never emerges.
    for (int i = 0; i < 5; i++)
      step("wr_rst", i == 0, (i + 1) * 65536, 3, 1'b0, 1'b0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 14; i++)
      step("wr_rst.after", 1'b0, (i + 9) * 65536, 3, 1'b0, 1'b0, 0, 0);

    // Recovery: a fresh frame after reset comes out normally.
    for (int i = 0; i < 18; i++) begin
      j  = i - 9;
      ev = (j >= 0 && j < 8);
      es = (j == 0);
      er = 0; ei = 0;
      if (ev) begin
        er = sc(perm[j] * 65536);
        ei = sc(perm[j] * 16);
      end
      step("recover", i == 0, i * 65536, i * 16, ev, es, er, ei);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
